// File: rtl/change_dispenser_pkg.sv
// rtl/change_dispenser_pkg.sv - coin values, amount width and dispenser state encodings
package change_dispenser_pkg;

    localparam int AMT_W  = 5;
    localparam int COIN_W = 4;

    localparam logic [COIN_W-1:0] COIN_1  = 4'd1;
    localparam logic [COIN_W-1:0] COIN_5  = 4'd5;
    localparam logic [COIN_W-1:0] COIN_10 = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PAY    = 3'd2,
        ST_FINISH = 3'd3,
        ST_SHORT  = 3'd4
    } state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - payout request, coin handshake, refill and status bundle
interface change_dispenser_if #(
    parameter int INV_W = 4
);

    logic                                       start;
    logic [change_dispenser_pkg::AMT_W-1:0]     change_amt;
    logic                                       coin_ack;
    logic                                       refill_valid;
    logic [change_dispenser_pkg::COIN_W-1:0]    refill_coin;
    logic [change_dispenser_pkg::COIN_W-1:0]    coin_out;
    logic                                       coin_valid;
    logic                                       busy;
    logic                                       done;
    logic                                       short_err;
    logic [change_dispenser_pkg::AMT_W-1:0]     remaining;
    logic [INV_W-1:0]                           inv1;
    logic [INV_W-1:0]                           inv5;
    logic [INV_W-1:0]                           inv10;

    modport master (
        output start, change_amt, coin_ack, refill_valid, refill_coin,
        input  coin_out, coin_valid, busy, done, short_err, remaining, inv1, inv5, inv10
    );

    modport slave (
        input  start, change_amt, coin_ack, refill_valid, refill_coin,
        output coin_out, coin_valid, busy, done, short_err, remaining, inv1, inv5, inv10
    );

endinterface

// File: rtl/change_coin_select.sv
// rtl/change_coin_select.sv - greedy choice of the largest stocked coin not exceeding the amount owed
module change_coin_select
    import change_dispenser_pkg::*;
(
    input  logic [AMT_W-1:0]  remaining_i,
    input  logic              has1_i,
    input  logic              has5_i,
    input  logic              has10_i,
    output logic [COIN_W-1:0] coin_o,
    output logic              found_o
);

    always_comb begin
        coin_o  = '0;
        found_o = 1'b0;
        if (has10_i && (remaining_i >= AMT_W'(COIN_10))) begin
            coin_o  = COIN_10;
            found_o = 1'b1;
        end else if (has5_i && (remaining_i >= AMT_W'(COIN_5))) begin
            coin_o  = COIN_5;
            found_o = 1'b1;
        end else if (has1_i && (remaining_i >= AMT_W'(COIN_1))) begin
            coin_o  = COIN_1;
            found_o = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out change one coin at a time from three refillable coin tubes
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int INV_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    change_dispenser_if.slave   bus
);

    state_t             state_q, state_d;
    logic [AMT_W-1:0]   rem_q, rem_d;
    logic [COIN_W-1:0]  coin_q, coin_d;
    logic               short_q, short_d;
    logic [INV_W-1:0]   inv1_q, inv5_q, inv10_q;

    logic [COIN_W-1:0]  sel_coin;
    logic               sel_found;
    logic               ack_take;

    change_coin_select u_select (
        .remaining_i (rem_q),
        .has1_i      (|inv1_q),
        .has5_i      (|inv5_q),
        .has10_i     (|inv10_q),
        .coin_o      (sel_coin),
        .found_o     (sel_found)
    );

    assign ack_take = (state_q == ST_PAY) && bus.coin_ack;

    // A refill and an ejection of the same coin in one cycle cancel out.
    function automatic logic [INV_W-1:0] inv_next(input logic [INV_W-1:0] cur,
                                                  input logic inc, input logic dec);
        logic [INV_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec && (cur != '1)) nxt = cur + 1'b1;
        if (dec && !inc)                nxt = cur - 1'b1;
        return nxt;
    endfunction

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        coin_d  = coin_q;
        short_d = short_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    rem_d   = bus.change_amt;
                    short_d = 1'b0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (rem_q == '0) begin
                    state_d = ST_FINISH;
                end else if (sel_found) begin
                    coin_d  = sel_coin;
                    state_d = ST_PAY;
                end else begin
                    state_d = ST_SHORT;
                end
            end
            ST_PAY: begin
                if (bus.coin_ack) begin
                    rem_d   = rem_q - AMT_W'(coin_q);
                    state_d = ST_SELECT;
                end
            end
            ST_FINISH: begin
                short_d = 1'b0;
                state_d = ST_IDLE;
            end
            ST_SHORT: begin
                short_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            coin_q  <= '0;
            short_q <= 1'b0;
            inv1_q  <= '0;
            inv5_q  <= '0;
            inv10_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            coin_q  <= coin_d;
            short_q <= short_d;
            inv1_q  <= inv_next(inv1_q,
                                bus.refill_valid && (bus.refill_coin == COIN_1),
                                ack_take && (coin_q == COIN_1));
            inv5_q  <= inv_next(inv5_q,
                                bus.refill_valid && (bus.refill_coin == COIN_5),
                                ack_take && (coin_q == COIN_5));
            inv10_q <= inv_next(inv10_q,
                                bus.refill_valid && (bus.refill_coin == COIN_10),
                                ack_take && (coin_q == COIN_10));
        end
    end

    assign bus.coin_valid = (state_q == ST_PAY);
    assign bus.coin_out   = (state_q == ST_PAY) ? coin_q : '0;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_FINISH) || (state_q == ST_SHORT);
    assign bus.short_err  = short_q;
    assign bus.remaining  = rem_q;
    assign bus.inv1       = inv1_q;
    assign bus.inv5       = inv5_q;
    assign bus.inv10      = inv10_q;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter INV_W, default 4, width of each per-denomination coin inventory counter (saturates at 2^INV_W-1).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to pay out change_amt; honoured only in IDLE.
REQ-005 change_amt  input  5  change to return, units 0..31.
REQ-006 coin_ack  input  1  coin mechanism has ejected the presented coin.
REQ-007 refill_valid  input  1  one coin loaded into the tube this cycle.
REQ-008 refill_coin  input  4  denomination of loaded coin (1, 5 or 10).
REQ-009 coin_out  output  4  denomination presented for ejection; 0 when coin_valid=0.
REQ-010 coin_valid  output  1  coin_out is valid, held until coin_ack.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at payout completion, success or shortfall.
REQ-013 short_err  output  1  sticky: last payout ended with undispensed change.
REQ-014 remaining  output  5  change still owed.
REQ-015 inv1, inv5, inv10  output  INV_W each  current coin counts per denomination.

Function
REQ-016 States: IDLE, SELECT, PAY, FINISH, SHORT; no other reachable state; undefined encodings go to IDLE.
REQ-017 IDLE, start=1: latch change_amt into remaining, clear short_err, go SELECT next cycle; start in other states ignored.
REQ-018 SELECT: if remaining=0 go FINISH; else pick the largest denomination d in {10,5,1} with d<=remaining and inventory(d)>0, latch it, go PAY; if none qualifies go SHORT.
REQ-019 PAY: coin_valid=1, coin_out=latched d, stable until coin_ack; coin_ack outside PAY ignored.
REQ-020 PAY with coin_ack=1: remaining<=remaining-d, inventory(d) decremented, go SELECT next cycle; one coin per PAY visit.
REQ-021 Latency: start at edge t -> coin_valid high from edge t+2; each ack -> next coin_valid at earliest 2 cycles later.
REQ-022 FINISH: done=1 for one cycle, short_err=0, go IDLE.
REQ-023 SHORT: done=1 for one cycle, short_err<=1, remaining holds unpaid value until next start, go IDLE.
REQ-024 Refill accepted in every state: refill_valid with refill_coin in {1,5,10} increments that counter, saturating at max; other codes ignored, no error.
REQ-025 Refill and ack on the same denomination in the same cycle: counter unchanged (net zero); different denominations update independently.
REQ-026 Arithmetic 5-bit unsigned; selection guarantees remaining-d never underflows.
REQ-027 change_amt=0: start -> SELECT -> FINISH, done at t+2, no coin presented.

Reset
REQ-028 rst overrides all inputs, mid-payout included: state=IDLE, remaining=0, coin_valid=0, coin_out=0, done=0, short_err=0, busy=0, all inventories=0.
REQ-029 A coin_ack coincident with rst is discarded; no inventory change.

Structure
REQ-030 Shared package holds the coin value constants (1, 5, 10), state encodings and the 5-bit amount width, also used by the vending machine controller.
REQ-031 Denomination choice lives in one combinational sub-module change_coin_select (inputs remaining and three inventory-nonzero flags; outputs chosen coin and found flag); everything else in change_dispenser.

Verification
REQ-032 Inventory 2/2/5 (1/5/10), start amt=17 -> coins 10,5,1,1 each acked; done with short_err=0, remaining=0, inventories 0/1/4.
REQ-033 Inventory 1/0/3, start amt=8 -> coin 1 only, then SHORT; done, short_err=1, remaining=7.
REQ-034 amt=0 -> done exactly 2 cycles after start, coin_valid never high.
REQ-035 coin_ack held low 5 cycles in PAY -> coin_out/coin_valid stable; refill of coin 5 during PAY with ack on coin 5 -> inv5 unchanged.
REQ-036 rst asserted in PAY after one acked coin -> next cycle all outputs and inventories 0, state IDLE; start ignored while busy.
REQ-037 15 refills of coin 10 into full counter (INV_W=4) -> inv10 saturates at 15; refill_coin=3 -> no counter change.
